fusionar_arriba: RTL and testbench
==================================

# fusionar_arriba

Sequential merge stage placed directly downstream of the upward-compaction stage in the 2048 move datapath. It takes a board whose tiles are already packed toward row 0 and merges equal vertically-adjacent pairs top-down, one column per cycle. It then re-packs each column, reports the score gained, reports whether the move changed the board, and flags a win when a 2048 tile is created. A start/done handshake lets the game controller sequence it after compaction and before new-tile spawning.

## Interface

Parameters:
- N, 4, board dimension (rows = columns = N); only 4 is supported.
- ANCHO, 12, tile value width in bits; a tile holds its face value (0 = empty).

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst_n  in  1  reset; one clock, asynchronous and active-low.
- inicio  in  1  start request; sampled only in IDLE.
- matriz_in  in  ANCHO x [0:3][0:3]  compacted board, indexed [row][col]; captured on accepted inicio.
- matriz_previa  in  ANCHO x [0:3][0:3]  board before compaction; captured with matriz_in and used for change detection.
- matriz  out  ANCHO x [0:3][0:3]  merged, re-compacted board.
- puntos  out  16  score gained this move (sum of merged tile values).
- cambio  out  1  1 when matriz differs from matriz_previa in any cell.
- gano  out  1  1 when any merge in this move produced 2048.
- ocupado  out  1  high from an accepted inicio until listo.
- listo  out  1  one-cycle pulse when outputs are valid.

## Operation

- FSM states: IDLE, CARGA, FUSION, FIN.
  - IDLE: when inicio=1, capture both boards into internal registers and go to CARGA.
  - CARGA: clear the column counter, puntos and gano; go to FUSION.
  - FUSION: process column col (0..3), one per cycle; after col=3, go to FIN.
  - FIN: compute cambio, pulse listo, return to IDLE.
- Per-column rule, applied top-down to a0..a3 (rows 0..3):
  - If a0≠0, a0=a1 and a0≠2048: r0=2·a0. Then if a2≠0, a2=a3 and a2≠2048, r1=2·a2; otherwise r1=a2, r2=a3.
  - Otherwise r0=a0. Then try the same merge test on (a1,a2), then on (a2,a3).
  - Remaining slots are 0. Each tile merges at most once per move.
- Each merge adds its result value to puntos. A merge result of 2048 sets gano.
- Two 2048 tiles never merge, so the 12-bit width cannot overflow.
- Input precondition: each column of matriz_in is compacted (no nonzero tile below a zero). Output for a non-compacted input is undefined.
- Bound: puntos ≤ 8·2048 = 16384, which fits in 16 bits.
- inicio while ocupado=1 is ignored; it is neither queued nor does it restart the move.
- matriz, puntos, cambio and gano hold their values from listo until the next accepted inicio.

## Timing

- Reset values: state=IDLE, matriz=all 0, puntos=0, cambio=0, gano=0, ocupado=0, listo=0.
- Edge k samples inicio=1 in IDLE. From cycle k+1 to k+6, ocupado=1.
- Column 0 is written at the edge ending CARGA+1, columns 1..3 on the following edges.
- listo=1 for exactly cycle k+6, during which ocupado is still 1. Total latency: 6 cycles.
- inicio sampled in the cycle after listo is accepted, so back-to-back moves are possible.
- rst_n low mid-operation: all outputs return to their reset values immediately (asynchronously) and no listo is produced.

## Structure

- Package juego_pkg holds:
  - typedef casilla_t = logic [11:0];
  - typedef tablero_t = casilla_t [0:3][0:3];
  - constants N=4 and CASILLA_MAX=12'd2048;
  - enum estado_fusion_t {IDLE, CARGA, FUSION, FIN}.
- Sub-module fusion_columna (combinational): inputs four casilla_t; outputs four casilla_t, 16-bit column points and a win bit. Instantiated once and muxed by the column counter.

## Test plan

- Column 0 = [2,2,4,4], other columns 0, previa equal to in → column 0 = [4,8,0,0], puntos=12, cambio=1, gano=0, listo at cycle k+6.
- Column 2 = [2,2,2,0] → [4,2,0,0], puntos=4. Column 3 = [8,8,8,8] → [16,16,0,0], puntos adds 32.
- Column 1 = [1024,1024,2048,2048] → [2048,2048,2048,0] only if the second pair is legal; required result is [2048,2048,2048,0] with gano=1, puntos=2048, and the 2048 pair unmerged.
- Board with no equal neighbours and matriz_previa = matriz_in → matriz unchanged, puntos=0, cambio=0. Same board with matriz_previa differing (compaction moved a tile) → cambio=1.
- inicio held high for 10 cycles → exactly one move per IDLE visit, with listo at k+6 and the next acceptance at k+7.
- rst_n asserted in cycle k+3 → outputs 0 within the same cycle, no listo; a fresh inicio after release completes normally.

Source files
------------

// File: rtl/juego_pkg.sv
// Shared types and constants for the 2048 move datapath.
// Combinational helpers only; no state lives here.
// Used by the merge stage and its column sub-module.
package juego_pkg;

  localparam int N = 4;

  typedef logic [11:0] casilla_t;
  typedef casilla_t tablero_t [0:3][0:3];

  localparam casilla_t CASILLA_MAX = 12'd2048;

  typedef enum logic [1:0] {
    IDLE,
    CARGA,
    FUSION,
    FIN
  } estado_fusion_t;

  // Two adjacent tiles merge when non-empty, equal and below the winning value
  function automatic logic se_funden(input casilla_t x, input casilla_t y);
    return (x != '0) && (x == y) && (x != CASILLA_MAX);
  endfunction

  // Merge result: twice the face value (never overflows since 2048 never merges)
  function automatic casilla_t doble(input casilla_t x);
    return {x[10:0], 1'b0};
  endfunction

  // Zero-extend a tile value to the score width
  function automatic logic [15:0] a_puntos(input casilla_t x);
    return {4'b0000, x};
  endfunction

endpackage

// File: rtl/fusion_columna.sv
// Merges one compacted column top-down and re-packs it toward row 0.
// Purely combinational, zero latency.
// No flow control; the caller muxes the column in and out.
module fusion_columna
  import juego_pkg::*;
(
  input  casilla_t    i_a0,
  input  casilla_t    i_a1,
  input  casilla_t    i_a2,
  input  casilla_t    i_a3,
  output casilla_t    o_r0,
  output casilla_t    o_r1,
  output casilla_t    o_r2,
  output casilla_t    o_r3,
  output logic [15:0] o_puntos,
  output logic        o_gano
);

  logic w_m01, w_m12, w_m23;

  assign w_m01 = se_funden(i_a0, i_a1);
  assign w_m12 = se_funden(i_a1, i_a2);
  assign w_m23 = se_funden(i_a2, i_a3);

  // Pair priority: (0,1) first, then (1,2), then (2,3); a consumed tile cannot merge again
  always_comb begin
    o_r0     = i_a0;
    o_r1     = i_a1;
    o_r2     = i_a2;
    o_r3     = i_a3;
    o_puntos = '0;
    o_gano   = 1'b0;
    if (w_m01) begin
      o_r0     = doble(i_a0);
      o_r3     = '0;
      o_puntos = a_puntos(doble(i_a0));
      o_gano   = (doble(i_a0) == CASILLA_MAX);
      if (w_m23) begin
        o_r1     = doble(i_a2);
        o_r2     = '0;
        o_puntos = a_puntos(doble(i_a0)) + a_puntos(doble(i_a2));
        o_gano   = (doble(i_a0) == CASILLA_MAX) || (doble(i_a2) == CASILLA_MAX);
      end else begin
        o_r1 = i_a2;
        o_r2 = i_a3;
      end
    end else if (w_m12) begin
      o_r1     = doble(i_a1);
      o_r2     = i_a3;
      o_r3     = '0;
      o_puntos = a_puntos(doble(i_a1));
      o_gano   = (doble(i_a1) == CASILLA_MAX);
    end else if (w_m23) begin
      o_r2     = doble(i_a2);
      o_r3     = '0;
      o_puntos = a_puntos(doble(i_a2));
      o_gano   = (doble(i_a2) == CASILLA_MAX);
    end
  end

endmodule

// File: rtl/fusionar_arriba.sv
// Upward merge stage: merges one column per cycle, reports score, change and win.
// Latency 6 cycles from accepted inicio to the listo pulse.
// inicio is ignored while ocupado; results hold until the next accepted inicio.
module fusionar_arriba #(
  parameter int N     = 4,
  parameter int ANCHO = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inicio,
  input  logic [ANCHO-1:0] matriz_in     [0:N-1][0:N-1],
  input  logic [ANCHO-1:0] matriz_previa [0:N-1][0:N-1],
  output logic [ANCHO-1:0] matriz        [0:N-1][0:N-1],
  output logic [15:0]      puntos,
  output logic             cambio,
  output logic             gano,
  output logic             ocupado,
  output logic             listo
);

  import juego_pkg::*;

  estado_fusion_t r_estado, w_sig;
  tablero_t       r_tablero;
  tablero_t       r_previa;
  logic [1:0]     r_col;
  logic [15:0]    r_puntos;
  logic           r_gano;
  logic           r_cambio;

  casilla_t       w_col_ent [0:3];
  casilla_t       w_col_sal [0:3];
  logic [15:0]    w_col_pts;
  logic           w_col_gano;
  logic           w_dif;

  // Select the column currently being merged
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      w_col_ent[r] = r_tablero[r][r_col];
    end
  end

  fusion_columna u_fusion_columna (
    .i_a0     (w_col_ent[0]),
    .i_a1     (w_col_ent[1]),
    .i_a2     (w_col_ent[2]),
    .i_a3     (w_col_ent[3]),
    .o_r0     (w_col_sal[0]),
    .o_r1     (w_col_sal[1]),
    .o_r2     (w_col_sal[2]),
    .o_r3     (w_col_sal[3]),
    .o_puntos (w_col_pts),
    .o_gano   (w_col_gano)
  );

  // Compare the board as it will look after this column's write against the pre-compaction board
  always_comb begin
    w_dif = 1'b0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (2'(c) == r_col) begin
          if (w_col_sal[r] != r_previa[r][c]) w_dif = 1'b1;
        end else begin
          if (r_tablero[r][c] != r_previa[r][c]) w_dif = 1'b1;
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_estado <= IDLE;
    else        r_estado <= w_sig;
  end

  // Next-state logic
  always_comb begin
    w_sig = r_estado;
    case (r_estado)
      IDLE:    if (inicio) w_sig = CARGA;
      CARGA:   w_sig = FUSION;
      FUSION:  if (r_col == 2'd3) w_sig = FIN;
      FIN:     w_sig = IDLE;
      default: w_sig = IDLE;
    endcase
  end

  // Handshake outputs decoded from state so reset clears them immediately
  always_comb begin
    ocupado = (r_estado != IDLE);
    listo   = (r_estado == FIN);
  end

  // Datapath: capture boards, walk columns, accumulate score and win; cambio settles with the last column
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tablero <= '{default: '0};
      r_previa  <= '{default: '0};
      r_col     <= '0;
      r_puntos  <= '0;
      r_gano    <= 1'b0;
      r_cambio  <= 1'b0;
    end else begin
      case (r_estado)
        IDLE: begin
          if (inicio) begin
            r_tablero <= matriz_in;
            r_previa  <= matriz_previa;
          end
        end
        CARGA: begin
          r_col    <= '0;
          r_puntos <= '0;
          r_gano   <= 1'b0;
        end
        FUSION: begin
          for (int r = 0; r < 4; r++) begin
            r_tablero[r][r_col] <= w_col_sal[r];
          end
          r_puntos <= r_puntos + w_col_pts;
          r_gano   <= r_gano | w_col_gano;
          r_col    <= r_col + 2'd1;
          if (r_col == 2'd3) r_cambio <= w_dif;
        end
        default: ;
      endcase
    end
  end

  assign matriz = r_tablero;
  assign puntos = r_puntos;
  assign cambio = r_cambio;
  assign gano   = r_gano;

endmodule

// File: tb/tb_fusionar_arriba.sv
// Scoreboard bench for fusionar_arriba: stimulus pushes expected results,
// a negedge monitor pops and compares on every listo pulse.
module tb_fusionar_arriba;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inicio = 1'b0;
  logic [11:0] m_in   [0:3][0:3];
  logic [11:0] m_prev [0:3][0:3];
  logic [11:0] m_out  [0:3][0:3];
  logic [15:0] puntos;
  logic        cambio, gano, ocupado, listo;

  typedef struct packed {
    logic [15:0][11:0] t;
    logic [15:0]       pts;
    logic              cam;
    logic              gan;
    logic [31:0]       ciclo;
  } esp_t;

  esp_t              cola[$];
  int                compared = 0;
  int                mismatched = 0;
  int                cyc = 0;
  logic [15:0][11:0] e_t;

  fusionar_arriba #(.N(4), .ANCHO(12)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .inicio        (inicio),
    .matriz_in     (m_in),
    .matriz_previa (m_prev),
    .matriz        (m_out),
    .puntos        (puntos),
    .cambio        (cambio),
    .gano          (gano),
    .ocupado       (ocupado),
    .listo         (listo)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nom, input logic [31:0] got, input logic [31:0] want);
    compared++;
    if (got !== want) begin
      mismatched++;
      $display("FAIL %s: got %0d want %0d (cyc %0d)", nom, got, want, cyc);
    end
  endtask

  // Monitor: every listo must match the oldest pending expectation
  always @(negedge clk) begin
    esp_t e;
    logic bad;
    if (rst_n && listo) begin
      if (cola.size() == 0) begin
        chk("listo_inesperado", 32'd1, 32'd0);
      end else begin
        e = cola.pop_front();
        bad = 1'b0;
        for (int r = 0; r < 4; r++)
          for (int c = 0; c < 4; c++)
            if (m_out[r][c] !== e.t[r*4+c]) begin
              bad = 1'b1;
              $display("FAIL matriz[%0d][%0d]: got %0d want %0d", r, c, m_out[r][c], e.t[r*4+c]);
            end
        compared++;
        if (bad) mismatched++;
        chk("puntos", 32'(puntos), 32'(e.pts));
        chk("cambio", 32'(cambio), 32'(e.cam));
        chk("gano", 32'(gano), 32'(e.gan));
        chk("latencia_listo", 32'(cyc), e.ciclo);
        chk("ocupado_en_listo", 32'(ocupado), 32'd1);
      end
    end
  end

  task automatic limpiar();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++) begin
        m_in[r][c]   = '0;
        m_prev[r][c] = '0;
      end
    e_t = '0;
  endtask

  task automatic pon_col(input int c, input logic [11:0] a0, a1, a2, a3);
    m_in[0][c] = a0; m_in[1][c] = a1; m_in[2][c] = a2; m_in[3][c] = a3;
  endtask

  task automatic esp_col(input int c, input logic [11:0] r0, r1, r2, r3);
    e_t[0*4+c] = r0; e_t[1*4+c] = r1; e_t[2*4+c] = r2; e_t[3*4+c] = r3;
  endtask

  task automatic copiar_prev();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        m_prev[r][c] = m_in[r][c];
  endtask

  task automatic empujar(input logic [15:0] pts, input logic cam, input logic gan, input int ciclo);
    esp_t e;
    e.t = e_t; e.pts = pts; e.cam = cam; e.gan = gan; e.ciclo = 32'(ciclo);
    cola.push_back(e);
  endtask

  // One-cycle inicio pulse; acceptance edge is the next posedge
  task automatic lanzar(input logic [15:0] pts, input logic cam, input logic gan);
    @(negedge clk);
    inicio = 1'b1;
    empujar(pts, cam, gan, cyc + 6);
    @(negedge clk);
    inicio = 1'b0;
  endtask

  task automatic esperar_vacia();
    for (int i = 0; i < 40 && cola.size() != 0; i++) @(negedge clk);
    if (cola.size() != 0) begin
      chk("timeout_listo", 32'(cola.size()), 32'd0);
      cola.delete();
    end
    @(negedge clk);
  endtask

  task automatic chk_salidas_cero(input string nom);
    logic bad;
    bad = 1'b0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (m_out[r][c] !== 12'd0) bad = 1'b1;
    chk({nom, "_matriz_cero"}, 32'(bad), 32'd0);
    chk({nom, "_puntos"}, 32'(puntos), 32'd0);
    chk({nom, "_cambio"}, 32'(cambio), 32'd0);
    chk({nom, "_gano"}, 32'(gano), 32'd0);
    chk({nom, "_ocupado"}, 32'(ocupado), 32'd0);
    chk({nom, "_listo"}, 32'(listo), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cyc %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    limpiar();
    repeat (2) @(negedge clk);
    chk_salidas_cero("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Column 0 = [2,2,4,4]
    limpiar();
    pon_col(0, 12'd2, 12'd2, 12'd4, 12'd4);
    copiar_prev();
    esp_col(0, 12'd4, 12'd8, 12'd0, 12'd0);
    lanzar(16'd12, 1'b1, 1'b0);
    esperar_vacia();

    // Column 2 = [2,2,2,0], column 3 = [8,8,8,8]
    limpiar();
    pon_col(2, 12'd2, 12'd2, 12'd2, 12'd0);
    pon_col(3, 12'd8, 12'd8, 12'd8, 12'd8);
    copiar_prev();
    esp_col(2, 12'd4, 12'd2, 12'd0, 12'd0);
    esp_col(3, 12'd16, 12'd16, 12'd0, 12'd0);
    lanzar(16'd36, 1'b1, 1'b0);
    esperar_vacia();

    // Column 1 = [1024,1024,2048,2048]: the 2048 pair must stay unmerged
    limpiar();
    pon_col(1, 12'd1024, 12'd1024, 12'd2048, 12'd2048);
    copiar_prev();
    esp_col(1, 12'd2048, 12'd2048, 12'd2048, 12'd0);
    lanzar(16'd2048, 1'b1, 1'b1);
    esperar_vacia();

    // No equal neighbours, previa identical -> no change
    limpiar();
    pon_col(0, 12'd2, 12'd4, 12'd8, 12'd16);
    pon_col(1, 12'd4, 12'd8, 12'd16, 12'd32);
    pon_col(2, 12'd8, 12'd16, 12'd32, 12'd64);
    pon_col(3, 12'd16, 12'd32, 12'd64, 12'd128);
    copiar_prev();
    esp_col(0, 12'd2, 12'd4, 12'd8, 12'd16);
    esp_col(1, 12'd4, 12'd8, 12'd16, 12'd32);
    esp_col(2, 12'd8, 12'd16, 12'd32, 12'd64);
    esp_col(3, 12'd16, 12'd32, 12'd64, 12'd128);
    lanzar(16'd0, 1'b0, 1'b0);
    esperar_vacia();

    // Same board, previa differs in one cell -> cambio
    m_prev[0][0] = 12'd0;
    m_prev[1][0] = 12'd2;
    lanzar(16'd0, 1'b1, 1'b0);
    esperar_vacia();

    // inicio held for 10 cycles: accepted at E and again at E+7
    limpiar();
    pon_col(0, 12'd2, 12'd2, 12'd4, 12'd4);
    copiar_prev();
    esp_col(0, 12'd4, 12'd8, 12'd0, 12'd0);
    @(negedge clk);
    inicio = 1'b1;
    e0 = cyc + 1;
    empujar(16'd12, 1'b1, 1'b0, e0 + 5);
    empujar(16'd12, 1'b1, 1'b0, e0 + 12);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (cyc == e0 + 6) chk("ocupado_ciclo_k7", 32'(ocupado), 32'd0);
      if (cyc == e0 + 7) chk("ocupado_tras_reacepta", 32'(ocupado), 32'd1);
    end
    inicio = 1'b0;
    esperar_vacia();
    repeat (3) @(negedge clk);
    chk("sin_tercera_aceptacion", 32'(ocupado), 32'd0);

    // Reset asserted in cycle k+3 of a move: no listo, outputs cleared at once
    limpiar();
    pon_col(1, 12'd1024, 12'd1024, 12'd2048, 12'd2048);
    copiar_prev();
    @(negedge clk);
    inicio = 1'b1;
    @(negedge clk);
    inicio = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("ocupado_antes_reset", 32'(ocupado), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_salidas_cero("reset_medio");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);

    // Fresh move after reset release
    limpiar();
    pon_col(0, 12'd4, 12'd4, 12'd4, 12'd4);
    pon_col(1, 12'd2, 12'd0, 12'd0, 12'd0);
    pon_col(2, 12'd1024, 12'd1024, 12'd0, 12'd0);
    pon_col(3, 12'd2, 12'd4, 12'd4, 12'd0);
    copiar_prev();
    esp_col(0, 12'd8, 12'd8, 12'd0, 12'd0);
    esp_col(1, 12'd2, 12'd0, 12'd0, 12'd0);
    esp_col(2, 12'd2048, 12'd0, 12'd0, 12'd0);
    esp_col(3, 12'd2, 12'd8, 12'd0, 12'd0);
    lanzar(16'd2072, 1'b1, 1'b1);
    esperar_vacia();

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
